// File: rtl/counter_step_ctrl.sv
// Step sequencer for the 8-bit up/down step counter: arbitrates manual
// up/down requests against a prescaled auto-run generator (wrap or bounce).
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset (shared with counter)
//   man_up, man_dn  : single-cycle manual step requests
//   run_en          : auto-run enable (level)
//   mode            : 0 = wrap (auto up), 1 = bounce between lo_lim and hi_lim
//   div             : auto step period minus one
//   lo_lim, hi_lim  : bounce limits
//   PED, uphdnl     : registered step pulse and direction to the counter
//   shadow_count    : local mirror of the counter value
//   dir_up          : current bounce direction
//   cfg_err         : bounce mode with lo_lim >= hi_lim
module counter_step_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             man_up,
    input  logic             man_dn,
    input  logic             run_en,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] lo_lim,
    input  logic [CNT_W-1:0] hi_lim,
    output logic             PED,
    output logic             uphdnl,
    output logic [CNT_W-1:0] shadow_count,
    output logic             dir_up,
    output logic             cfg_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic               ped_q, ped_d;
    logic               uphdnl_q, uphdnl_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic               dir_up_q, dir_up_d;
    logic               cfg_err_q, cfg_err_d;

    logic               tick;
    logic               step;
    logic               step_up;

    always_comb begin
        state_d   = state_q;
        pre_d     = '0;
        tick      = 1'b0;
        step      = 1'b0;
        step_up   = uphdnl_q;
        dir_up_d  = dir_up_q;
        cfg_err_d = mode && (lo_lim >= hi_lim);

        unique case (state_q)
            IDLE: if (run_en) state_d = RUN;
            RUN:  if (!run_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Count 0..div; a count already past a freshly lowered div
        // falls back to 0 without producing a tick.
        if (state_q == RUN && run_en) begin
            if (pre_q == div) begin
                tick = 1'b1;
            end else if (pre_q < div) begin
                pre_d = pre_q + DIV_W'(1);
            end
        end

        // The step currently on PED lands in the counter at the next edge,
        // so shadow_d is the value the counter will hold; limit decisions
        // use it so back-to-back auto steps never overshoot.
        shadow_d = shadow_q;
        if (ped_q) begin
            shadow_d = uphdnl_q ? shadow_q + CNT_W'(1)
                                : shadow_q - CNT_W'(1);
        end

        if (man_up && !man_dn) begin
            step    = 1'b1;
            step_up = 1'b1;
        end else if (man_dn && !man_up) begin
            step    = 1'b1;
            step_up = 1'b0;
        end else if (tick) begin
            if (!mode) begin
                step    = 1'b1;
                step_up = 1'b1;
            end else if (!cfg_err_q) begin
                step = 1'b1;
                if (dir_up_q && shadow_d >= hi_lim) begin
                    dir_up_d = 1'b0;
                    step_up  = 1'b0;
                end else if (!dir_up_q && shadow_d <= lo_lim) begin
                    dir_up_d = 1'b1;
                    step_up  = 1'b1;
                end else begin
                    step_up = dir_up_q;
                end
            end
        end

        ped_d    = step;
        uphdnl_d = step ? step_up : uphdnl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            ped_q     <= 1'b0;
            uphdnl_q  <= 1'b1;
            shadow_q  <= '0;
            dir_up_q  <= 1'b1;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            ped_q     <= ped_d;
            uphdnl_q  <= uphdnl_d;
            shadow_q  <= shadow_d;
            dir_up_q  <= dir_up_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign PED          = ped_q;
    assign uphdnl       = uphdnl_q;
    assign shadow_count = shadow_q;
    assign dir_up       = dir_up_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl: vector table for manual stepping
// plus hand-written auto-run, bounce, arbitration and reset sequences.
module tb_counter_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        man_up, man_dn, run_en, mode;
    logic [15:0] div;
    logic [7:0]  lo_lim, hi_lim;
    logic        PED, uphdnl, dir_up, cfg_err;
    logic [7:0]  shadow_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_step_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .man_up       (man_up),
        .man_dn       (man_dn),
        .run_en       (run_en),
        .mode         (mode),
        .div          (div),
        .lo_lim       (lo_lim),
        .hi_lim       (hi_lim),
        .PED          (PED),
        .uphdnl       (uphdnl),
        .shadow_count (shadow_count),
        .dir_up       (dir_up),
        .cfg_err      (cfg_err)
    );

    typedef struct {
        logic       up, dn, mode;
        logic [7:0] lo, hi;
        logic       e_ped, e_up;
        logic [7:0] e_sh;
        logic       e_dir, e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        man_up = 0; man_dn = 0; run_en = 0; mode = 0;
        div = 16'd0; lo_lim = 8'd2; hi_lim = 8'd5;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        tick_clk();
        tick_clk();
        reset = 0;
    endtask

    function automatic vec_t mk(input logic up, dn, md,
                                input logic [7:0] lo, hi,
                                input logic p, u,
                                input logic [7:0] s,
                                input logic d, e);
        vec_t v;
        v.up = up; v.dn = dn; v.mode = md; v.lo = lo; v.hi = hi;
        v.e_ped = p; v.e_up = u; v.e_sh = s; v.e_dir = d; v.e_err = e;
        return v;
    endfunction

    int ped_cnt, first_ped, last_ped, gap_bad;
    logic [7:0] bexp_sh[10];
    logic       bexp_dir[10];

    initial begin
        //        up dn md lo hi  ped up  sh  dir err
        vecs[0]  = mk(0, 0, 0, 2, 5, 0, 1, 0,   1, 0);
        vecs[1]  = mk(1, 0, 0, 2, 5, 1, 1, 0,   1, 0);
        vecs[2]  = mk(0, 0, 0, 2, 5, 0, 1, 1,   1, 0);
        vecs[3]  = mk(0, 1, 0, 2, 5, 1, 0, 1,   1, 0);
        vecs[4]  = mk(0, 0, 0, 2, 5, 0, 0, 0,   1, 0);
        vecs[5]  = mk(0, 1, 0, 2, 5, 1, 0, 0,   1, 0);
        vecs[6]  = mk(0, 0, 0, 2, 5, 0, 0, 255, 1, 0);
        vecs[7]  = mk(1, 1, 0, 2, 5, 0, 0, 255, 1, 0);
        vecs[8]  = mk(1, 0, 0, 2, 5, 1, 1, 255, 1, 0);
        vecs[9]  = mk(1, 0, 0, 2, 5, 1, 1, 0,   1, 0);
        vecs[10] = mk(0, 0, 0, 2, 5, 0, 1, 1,   1, 0);
        vecs[11] = mk(0, 0, 1, 7, 7, 0, 1, 1,   1, 1);
        vecs[12] = mk(0, 1, 1, 7, 7, 1, 0, 1,   1, 1);
        vecs[13] = mk(0, 0, 0, 2, 5, 0, 0, 0,   1, 0);

        bexp_sh  = '{1, 2, 3, 4, 5, 4, 3, 2, 3, 4};
        bexp_dir = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};

        do_reset();
        chk("rst_ped", PED, 0);
        chk("rst_up", uphdnl, 1);
        chk("rst_sh", shadow_count, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_err", cfg_err, 0);

        // Manual stepping table (run_en = 0 throughout)
        for (int i = 0; i < 14; i++) begin
            man_up = vecs[i].up; man_dn = vecs[i].dn;
            mode = vecs[i].mode;
            lo_lim = vecs[i].lo; hi_lim = vecs[i].hi;
            tick_clk();
            chk($sformatf("v%0d_ped", i), PED, vecs[i].e_ped);
            chk($sformatf("v%0d_up", i), uphdnl, vecs[i].e_up);
            chk($sformatf("v%0d_sh", i), shadow_count, vecs[i].e_sh);
            chk($sformatf("v%0d_dir", i), dir_up, vecs[i].e_dir);
            chk($sformatf("v%0d_err", i), cfg_err, vecs[i].e_err);
        end

        // Wrap auto-run, div=3, run_en held across 41 edges
        do_reset();
        div = 16'd3; run_en = 1;
        ped_cnt = 0; first_ped = -1; last_ped = 0; gap_bad = 0;
        for (int e = 1; e <= 41; e++) begin
            tick_clk();
            if (PED) begin
                if (first_ped < 0) first_ped = e;
                else if (e - last_ped != 4) gap_bad++;
                last_ped = e;
                ped_cnt++;
            end
        end
        chk("wrap_first", first_ped, 5);
        chk("wrap_gap", gap_bad, 0);
        chk("wrap_cnt", ped_cnt, 10);
        run_en = 0;
        ped_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            tick_clk();
            if (PED) ped_cnt++;
        end
        chk("wrap_sh", shadow_count, 10);
        chk("wrap_stop", ped_cnt, 0);

        // Bounce 2..5, div=0, from shadow=0
        do_reset();
        mode = 1; lo_lim = 8'd2; hi_lim = 8'd5; div = 16'd0;
        run_en = 1;
        tick_clk();
        tick_clk();
        for (int k = 0; k < 10; k++) begin
            tick_clk();
            chk($sformatf("bnc%0d_sh", k), shadow_count, bexp_sh[k]);
            chk($sformatf("bnc%0d_dir", k), dir_up, bexp_dir[k]);
        end

        // Manual down coincident with auto-up tick: only the down step
        do_reset();
        div = 16'd3; run_en = 1;
        for (int e = 1; e <= 4; e++) tick_clk();
        man_dn = 1;
        tick_clk();
        man_dn = 0;
        chk("coin_ped", PED, 1);
        chk("coin_dir", uphdnl, 0);
        tick_clk();
        chk("coin_ped6", PED, 0);
        chk("coin_sh", shadow_count, 255);
        tick_clk();
        chk("coin_ped7", PED, 0);

        // Bounce with lo == hi: cfg_err, no auto steps
        do_reset();
        mode = 1; lo_lim = 8'd7; hi_lim = 8'd7; div = 16'd0;
        run_en = 1;
        ped_cnt = 0;
        for (int e = 0; e < 8; e++) begin
            tick_clk();
            if (PED) ped_cnt++;
        end
        chk("cfg_err", cfg_err, 1);
        chk("cfg_noped", ped_cnt, 0);

        // Reset coincident with request, then reset over an in-flight PED
        do_reset();
        man_up = 1; reset = 1;
        tick_clk();
        chk("rq_rst_ped", PED, 0);
        reset = 0;
        tick_clk();
        man_up = 0;
        chk("pre_rst_ped", PED, 1);
        reset = 1;
        tick_clk();
        reset = 0;
        chk("fl_rst_ped", PED, 0);
        chk("fl_rst_up", uphdnl, 1);
        chk("fl_rst_sh", shadow_count, 0);
        chk("fl_rst_dir", dir_up, 1);
        chk("fl_rst_err", cfg_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_step_ctrl.md
Name: counter_step_ctrl

Overview:
- Sequencer that drives the 8-bit up/down step counter's step-pulse (PED) and direction (uphdnl) inputs.
- Arbitrates single-cycle manual up/down requests against an auto-run step generator with a programmable prescaler.
- Auto-run has two modes:
  - wrap: continuous up-count with natural 8-bit wrap.
  - bounce: ping-pong between a low and a high limit.
- Keeps a shadow copy of the counter value so limit decisions are made locally, without a read-back path.

Parameters:
- DIV_W, 16, width of prescaler divide value and internal prescale counter.
- CNT_W, 8, counter width; must equal the step counter's width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; same net as the step counter's reset
- man_up  in  1  single-cycle manual step-up request
- man_dn  in  1  single-cycle manual step-down request
- run_en  in  1  level; 1 = auto-run active
- mode  in  1  0 = wrap (auto steps up), 1 = bounce between lo_lim and hi_lim
- div  in  DIV_W  auto step period minus one, in clk cycles
- lo_lim  in  CNT_W  bounce low limit
- hi_lim  in  CNT_W  bounce high limit
- PED  out  1  registered one-cycle step pulse to the counter
- uphdnl  out  1  registered direction to the counter; 1 = up, 0 = down
- shadow_count  out  CNT_W  mirror of the counter value
- dir_up  out  1  current bounce direction
- cfg_err  out  1  bounce mode with lo_lim >= hi_lim

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (sync, active-high): PED=0, uphdnl=1, shadow_count=0, dir_up=1, prescale count=0, FSM=IDLE, cfg_err=0.
- FSM states:
  - IDLE -> RUN when run_en=1.
  - RUN -> IDLE when run_en=0; prescaler cleared on entry to IDLE.
- Prescaler (RUN only):
  - Counts 0..div; tick asserted in the cycle the count equals div, then count returns to 0.
  - div=0 gives a tick every cycle.
  - First tick occurs div+1 cycles after entering RUN.
  - A change of div mid-count takes effect immediately. If the current count already exceeds the new div, count returns to 0 on the next cycle with no tick.
- Step request resolution, evaluated each cycle, priority order:
  1. man_up && man_dn together: no manual step; a coincident tick is still served.
  2. Exactly one manual request: step in that direction. Any coincident tick is dropped, not deferred.
  3. Tick in wrap mode: step up.
  4. Tick in bounce mode, cfg_err=0:
     - If dir_up=1 and shadow_count >= hi_lim: dir_up<=0, step down.
     - Else if dir_up=0 and shadow_count <= lo_lim: dir_up<=1, step up.
     - Otherwise step in direction dir_up.
  5. Tick in bounce mode, cfg_err=1: no step.
- Manual steps are unconditional in every mode, including outside limits and in IDLE. They do not alter dir_up.
- Output timing:
  - Request resolved in cycle N -> PED=1 with uphdnl=direction in cycle N+1 (1-cycle latency).
  - PED is high for exactly one cycle per step; back-to-back steps give PED high on consecutive cycles.
  - When no step is issued, uphdnl holds its last value.
- Shadow tracking:
  - shadow_count updates on the same edge the counter samples PED: +1 if uphdnl else -1, modulo 2^CNT_W.
  - 255+1 -> 0 and 0-1 -> 255, matching the counter.
- cfg_err = mode && (lo_lim >= hi_lim), registered, 1-cycle latency.
- Out-of-range start in bounce mode (shadow below lo_lim while dir_up=0, or above hi_lim while dir_up=1) is handled by rule 4: direction flips toward the range.
- Reset mid-operation: an in-flight PED is squashed. Because the counter shares the reset, counter and shadow both return to 0.

Test Plan:
- Reset, then one man_up pulse -> PED=1, uphdnl=1 exactly one cycle later; shadow_count=1. Then man_dn pulse -> PED with uphdnl=0; shadow_count=0.
- man_dn from reset -> shadow_count=255 (wrap). man_up && man_dn together with run_en=0 -> no PED.
- mode=0, div=3, run_en=1 for 40 cycles -> PED every 4 cycles, first pulse at cycle 5 after run_en, shadow_count=10. Drop run_en -> no further PED.
- mode=1, lo_lim=2, hi_lim=5, div=0, start shadow=0 -> shadow sequence 1,2,3,4,5,4,3,2,3,4...; dir_up toggles at 5 and 2.
- Tick coincident with man_dn during an auto-up run -> a single down step only, no extra up step. lo_lim=7, hi_lim=7, mode=1 -> cfg_err=1, no auto PED.
- reset asserted in the cycle after a request -> PED not issued, all outputs at reset values next cycle.
